keypad_controller: RTL and testbench

Control FSM for the keypad scanner datapath. Sequences column scanning, row synchronisation, debounce, the post-debounce recheck, and the one-shot write of the decoded key into the segment registers. Consumes the datapath status flags (`buttonpush`, `synch_done`, `debounce_done`, `post_debounce`) and drives its enables. One key press produces exactly one `WE_send` pulse, however long the key is held.

---
 rtl/keypad_controller.sv | 131 +++++++++++++
 tb/tb_keypad_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_controller.sv
// Keypad scanner control FSM: scan, synch, debounce, recheck, one-shot send.
// Optional key-up debounce state compiled in with KEYPAD_RELEASE_DEBOUNCE_EN.
module keypad_controller #(
  parameter int SCAN_DIV       = 50000,
  parameter int RELEASE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buttonpush,
  input  logic       synch_done,
  input  logic       debounce_done,
  input  logic       post_debounce,
  output logic       scan_counter_en,
  output logic       WE_synch,
  output logic       debounce_counter_en,
  output logic       check_again,
  output logic       WE_send,
  output logic [2:0] state
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_SYNCH    = 3'd1,
    S_DEBOUNCE = 3'd2,
    S_CHECK    = 3'd3,
    S_SEND     = 3'd4,
    S_HOLD     = 3'd5,
    S_RELEASE  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] presc_q, presc_d;

`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RW-1:0] REL_MAX = RW'(RELEASE_CYCLES - 1);

  logic [RW-1:0] rel_q, rel_d;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = '0;
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
    rel_d   = '0;
`endif
    case (state_q)
      S_SCAN: begin
        if (buttonpush) begin
          state_d = S_SYNCH;
        end else if (presc_q == SCAN_MAX) begin
          presc_d = '0;
        end else begin
          presc_d = presc_q + SW'(1);
        end
      end
      S_SYNCH: begin
        if (synch_done) begin
          state_d = S_DEBOUNCE;
        end else if (!buttonpush) begin
          state_d = S_SCAN;
        end
      end
      S_DEBOUNCE: begin
        if (debounce_done) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = post_debounce ? S_SEND : S_SCAN;
      end
      S_SEND: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!buttonpush) begin
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
          state_d = S_RELEASE;
`else
          state_d = S_SCAN;
`endif
        end
      end
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
      // Any bounce back to pressed restarts the release window.
      S_RELEASE: begin
        if (buttonpush) begin
          state_d = S_HOLD;
        end else if (rel_q == REL_MAX) begin
          state_d = S_SCAN;
        end else begin
          rel_d = rel_q + RW'(1);
        end
      end
`endif
      default: begin
        state_d = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SCAN;
      presc_q <= '0;
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
      rel_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
      rel_q   <= rel_d;
`endif
    end
  end

  // Strobe is withheld while a key is down so the column stays on it.
  assign scan_counter_en     = (state_q == S_SCAN) &&
                               (presc_q == SCAN_MAX) &&
                               !buttonpush;
  assign WE_synch            = (state_q == S_SYNCH);
  assign debounce_counter_en = (state_q == S_DEBOUNCE);
  assign check_again         = (state_q == S_CHECK);
  assign WE_send             = (state_q == S_SEND);
  assign state               = state_q;

endmodule

// File: tb/tb_keypad_controller.sv
// Table-driven bench for keypad_controller with SCAN_DIV=4, RELEASE_CYCLES=8.
// Vectors are pushed to a scoreboard queue when driven, popped when sampled.
module tb_keypad_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       buttonpush;
  logic       synch_done;
  logic       debounce_done;
  logic       post_debounce;
  logic       scan_counter_en;
  logic       WE_synch;
  logic       debounce_counter_en;
  logic       check_again;
  logic       WE_send;
  logic [2:0] state;

  keypad_controller #(
    .SCAN_DIV(4),
    .RELEASE_CYCLES(8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .buttonpush          (buttonpush),
    .synch_done          (synch_done),
    .debounce_done       (debounce_done),
    .post_debounce       (post_debounce),
    .scan_counter_en     (scan_counter_en),
    .WE_synch            (WE_synch),
    .debounce_counter_en (debounce_counter_en),
    .check_again         (check_again),
    .WE_send             (WE_send),
    .state               (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       bp;
    logic       sd;
    logic       dd;
    logic       pd;
    logic [2:0] st;
    logic       scan;
    logic       wsy;
    logic       den;
    logic       chk;
    logic       wse;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_send = 0;

  task automatic add(input logic rst, input logic bp,
                     input logic sd, input logic dd,
                     input logic pd, input logic [2:0] st,
                     input logic scan, input logic wsy,
                     input logic den, input logic chk,
                     input logic wse);
    vec_t v;
    v.rst = rst; v.bp = bp; v.sd = sd; v.dd = dd; v.pd = pd;
    v.st = st; v.scan = scan; v.wsy = wsy; v.den = den;
    v.chk = chk; v.wse = wse;
    tbl.push_back(v);
  endtask

  // Quiet cycle in a state whose enables are all low.
  task automatic idle(input logic bp, input logic [2:0] st);
    add(0, bp, 0, 0, 0, st, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    buttonpush = 1'b0;
    synch_done = 1'b0;
    debounce_done = 1'b0;
    post_debounce = 1'b0;

    // Reset held: all zero
    add(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    // Idle scan: strobe on cycles 4,8,12,16,20
    for (int i = 1; i <= 20; i++)
      add(0, 0, 0, 0, 0, 3'd0, (i % 4) == 0, 0, 0, 0, 0);
    idle(0, 3'd0);
    idle(0, 3'd0);
    idle(0, 3'd0);
    // Clean press on the strobe cycle: strobe suppressed
    add(0, 1, 1, 1, 1, 3'd0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 3'd1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1, 3'd2, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 3'd3, 0, 0, 0, 1, 0);
    add(0, 1, 1, 1, 1, 3'd4, 0, 0, 0, 0, 1);
    // Long hold
    for (int i = 0; i < 1000; i++)
      add(0, 1, 1, 1, 1, 3'd5, 0, 0, 0, 0, 0);
`ifdef KEYPAD_RELEASE_DEBOUNCE_EN
    idle(0, 3'd5);
    for (int i = 0; i < 4; i++) idle(0, 3'd6);
    idle(1, 3'd6);
    idle(0, 3'd5);
    for (int i = 0; i < 8; i++) idle(0, 3'd6);
    idle(0, 3'd0);
`else
    idle(0, 3'd5);
    idle(0, 3'd0);
`endif
    // Prescaler restarts at 0 after leaving SCAN
    idle(0, 3'd0);
    idle(0, 3'd0);
    add(0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0);
    // Failed recheck
    add(0, 1, 1, 1, 0, 3'd0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3'd1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3'd2, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 3'd3, 0, 0, 0, 1, 0);
    idle(0, 3'd0);
    idle(0, 3'd0);
    idle(0, 3'd0);
    add(0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0);
    // SYNCH waits with key down, aborts on release
    idle(1, 3'd0);
    add(0, 1, 0, 0, 0, 3'd1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0, 0);
    idle(0, 3'd0);
    // Reset while in DEBOUNCE
    idle(1, 3'd0);
    add(0, 1, 1, 0, 0, 3'd1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 3'd2, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 3'd2, 0, 0, 1, 0, 0);
    idle(0, 3'd0);
    idle(0, 3'd0);
    idle(0, 3'd0);
    add(0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0);
    // Reset while in SEND: no WE_send afterwards
    add(0, 1, 1, 1, 1, 3'd0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 3'd1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1, 3'd2, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 3'd3, 0, 0, 0, 1, 0);
    add(1, 1, 1, 1, 1, 3'd4, 0, 0, 0, 0, 1);
    add(1, 1, 1, 1, 1, 3'd0, 0, 0, 0, 0, 0);
    idle(0, 3'd0);

    // Untracked power-up reset cycle
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      vec_t e;
      vec_t v;
      logic [7:0] act;
      logic [7:0] req;
      v = tbl[i];
      reset = v.rst;
      buttonpush = v.bp;
      synch_done = v.sd;
      debounce_done = v.dd;
      post_debounce = v.pd;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      act = {state, scan_counter_en, WE_synch,
             debounce_counter_en, check_again, WE_send};
      req = {e.st, e.scan, e.wsy, e.den, e.chk, e.wse};
      if (WE_send === 1'b1) n_send++;
      n_cmp++;
      if (act !== req) begin
        n_bad++;
        $display("FAIL vec%0d: got st=%0d en=%b, expected st=%0d en=%b",
                 i, act[7:5], act[4:0], req[7:5], req[4:0]);
      end
      @(posedge clk);
      #1;
    end

    // Two presses reached SEND; the second was cut by reset in SEND
    n_cmp++;
    if (n_send != 2) begin
      n_bad++;
      $display("FAIL we_send_count: got %0d, expected 2", n_send);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
